// File: rtl/mc_datapath.sv
// Multi-cycle CPU datapath: register file, ALU, PC, IR and a req/ack memory bus,
// sequenced one command at a time through IDLE -> EXEC -> (MEM) -> IDLE.
module mc_datapath #(
    parameter int WIDTH    = 32,
    parameter int AWIDTH   = 32,
    parameter int NREGS    = 32,
    parameter int RESET_PC = 0,
    parameter int PC_STEP  = 4,
    parameter int TIMEOUT  = 255,
    localparam int RBITS   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [3:0]        cmd_alu,
    input  logic [RBITS-1:0]  cmd_rd,
    input  logic [RBITS-1:0]  cmd_ra,
    input  logic [RBITS-1:0]  cmd_rb,
    input  logic [WIDTH-1:0]  cmd_lit,
    input  logic [1:0]        cmd_cond,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ack,
    output logic [AWIDTH-1:0] pc,
    output logic [WIDTH-1:0]  instr,
    output logic [3:0]        flags
);
    localparam int SHB = $clog2(WIDTH);
    localparam int CW  = $clog2(TIMEOUT + 1);
    localparam int M   = WIDTH - 1;

    localparam logic [2:0] OP_RR = 3'd0, OP_RI = 3'd1, OP_LD = 3'd2;
    localparam logic [2:0] OP_ST = 3'd3, OP_BR = 3'd4, OP_JAL = 3'd5;
    localparam logic [2:0] OP_FE = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM} state_t;

    state_t r_state, w_next;

    logic [2:0]        r_op;
    logic [3:0]        r_alu;
    logic [RBITS-1:0]  r_rd, r_ra, r_rb;
    logic [WIDTH-1:0]  r_lit;
    logic [1:0]        r_cond;
    logic [WIDTH-1:0]  r_regs [NREGS];
    logic [AWIDTH-1:0] r_pc;
    logic [WIDTH-1:0]  r_instr;
    logic [3:0]        r_flags;
    logic              r_done, r_err;
    logic              r_req, r_we;
    logic [AWIDTH-1:0] r_addr;
    logic [WIDTH-1:0]  r_wdata;
    logic [CW-1:0]     r_cnt;

    logic [WIDTH-1:0]  w_a, w_rb, w_opb, w_res, w_diff, w_pc_w;
    logic [WIDTH:0]    w_sum;
    logic              w_c, w_v, w_take, w_tmo, w_is_alu;
    logic              w_rf_we;
    logic [WIDTH-1:0]  w_rf_wd;
    logic [AWIDTH-1:0] w_ea;

    // r0 is hardwired to zero on the read side
    assign w_a      = (r_ra == '0) ? '0 : r_regs[r_ra];
    assign w_rb     = (r_rb == '0) ? '0 : r_regs[r_rb];
    assign w_opb    = (r_op == OP_RI) ? r_lit : w_rb;
    assign w_sum    = {1'b0, w_a} + {1'b0, w_opb};
    assign w_diff   = w_a - w_opb;
    assign w_ea     = AWIDTH'(w_a + r_lit);
    assign w_pc_w   = WIDTH'(r_pc);
    assign w_tmo    = (r_cnt == CW'(TIMEOUT - 1));
    assign w_is_alu = (r_op == OP_RR) || (r_op == OP_RI);

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (r_alu)
            4'd0: begin
                w_res = w_sum[M:0];
                w_c   = w_sum[WIDTH];
                w_v   = (w_a[M] == w_opb[M]) && (w_sum[M] != w_a[M]);
            end
            4'd1: begin
                w_res = w_diff;
                w_c   = (w_a >= w_opb);
                w_v   = (w_a[M] != w_opb[M]) && (w_diff[M] != w_a[M]);
            end
            4'd2: w_res = w_a & w_opb;
            4'd3: w_res = w_a | w_opb;
            4'd4: w_res = w_a ^ w_opb;
            4'd5: w_res = w_a << w_opb[SHB-1:0];
            4'd6: w_res = w_a >> w_opb[SHB-1:0];
            4'd7: w_res = WIDTH'($signed(w_a) >>> w_opb[SHB-1:0]);
            4'd8: w_res = w_opb;
            4'd9: w_res = {{(WIDTH-1){1'b0}}, $signed(w_a) < $signed(w_opb)};
            default: w_res = '0;
        endcase
    end

    always_comb begin
        case (r_cond)
            2'd0:    w_take = 1'b1;
            2'd1:    w_take = r_flags[3];
            2'd2:    w_take = r_flags[2];
            default: w_take = r_flags[1];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (cmd_valid) w_next = S_EXEC;
            S_EXEC: begin
                if (r_op == OP_LD || r_op == OP_ST || r_op == OP_FE)
                    w_next = S_MEM;
                else
                    w_next = S_IDLE;
            end
            S_MEM:  if (mem_ack || w_tmo) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE);
    end

    always_comb begin
        w_rf_we = 1'b0;
        w_rf_wd = '0;
        if (r_state == S_EXEC && w_is_alu) begin
            w_rf_we = 1'b1;
            w_rf_wd = w_res;
        end else if (r_state == S_EXEC && r_op == OP_JAL) begin
            w_rf_we = 1'b1;
            w_rf_wd = w_pc_w;
        end else if (r_state == S_MEM && mem_ack && r_op == OP_LD) begin
            w_rf_we = 1'b1;
            w_rf_wd = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_rf_we && r_rd != '0) begin
            r_regs[r_rd] <= w_rf_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= '0;
            r_alu   <= '0;
            r_rd    <= '0;
            r_ra    <= '0;
            r_rb    <= '0;
            r_lit   <= '0;
            r_cond  <= '0;
            r_pc    <= AWIDTH'(RESET_PC);
            r_instr <= '0;
            r_flags <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op   <= cmd_op;
                        r_alu  <= cmd_alu;
                        r_rd   <= cmd_rd;
                        r_ra   <= cmd_ra;
                        r_rb   <= cmd_rb;
                        r_lit  <= cmd_lit;
                        r_cond <= cmd_cond;
                    end
                end
                S_EXEC: begin
                    r_cnt <= '0;
                    case (r_op)
                        OP_RR, OP_RI: begin
                            r_flags <= {w_res == '0, w_res[M], w_c, w_v};
                            r_done  <= 1'b1;
                        end
                        OP_BR: begin
                            if (w_take) r_pc <= r_pc + AWIDTH'(r_lit);
                            r_done <= 1'b1;
                        end
                        OP_JAL: begin
                            r_pc   <= w_ea;
                            r_done <= 1'b1;
                        end
                        OP_LD: begin
                            r_addr <= w_ea;
                            r_we   <= 1'b0;
                            r_req  <= 1'b1;
                        end
                        OP_ST: begin
                            r_addr  <= w_ea;
                            r_wdata <= w_rb;
                            r_we    <= 1'b1;
                            r_req   <= 1'b1;
                        end
                        OP_FE: begin
                            r_addr <= r_pc;
                            r_we   <= 1'b0;
                            r_req  <= 1'b1;
                        end
                        default: begin
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        r_req  <= 1'b0;
                        r_we   <= 1'b0;
                        r_done <= 1'b1;
                        if (r_op == OP_FE) begin
                            r_instr <= mem_rdata;
                            r_pc    <= r_pc + AWIDTH'(PC_STEP);
                        end
                    end else if (w_tmo) begin
                        r_req  <= 1'b0;
                        r_we   <= 1'b0;
                        r_err  <= 1'b1;
                        r_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign done      = r_done;
    assign err       = r_err;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign pc        = r_pc;
    assign instr     = r_instr;
    assign flags     = r_flags;
endmodule
